brick_collision_sched: RTL and testbench

//  Per-frame collision scheduler/velocity arbiter for the bouncing-ball game. On each frame tick it scans
//  the brick list one brick per Clk, finds the first live brick overlapped by the ball, clears it, and

---
 rtl/game_pkg.sv | 34 +++
 rtl/brick_collision_sched_if.sv | 43 ++++
 rtl/brick_overlap.sv | 36 +++
 rtl/brick_collision_sched.sv | 212 +++++++++++++++++++++
 tb/tb_brick_collision_sched.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types for the brick collision scheduler: velocity codes, keycodes, FSM states.
// Latency: declarations only; flip_vel is purely combinational.
// Backpressure: none; consumers use the values directly.
package game_pkg;

  typedef logic [1:0] vel_t;

  localparam vel_t VEL_STOP = 2'b00;
  localparam vel_t VEL_POS  = 2'b01;
  localparam vel_t VEL_NEG  = 2'b10;

  // USB HID usage codes for the steering keys
  localparam logic [7:0] KEY_W = 8'd26;
  localparam logic [7:0] KEY_S = 8'd22;
  localparam logic [7:0] KEY_A = 8'd4;
  localparam logic [7:0] KEY_D = 8'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_COMMIT  = 2'd3
  } sched_state_t;

  // Reverse a direction; STOP and the unused code 11 pass through unchanged
  function automatic vel_t flip_vel(input vel_t v);
    case (v)
      VEL_POS: flip_vel = VEL_NEG;
      VEL_NEG: flip_vel = VEL_POS;
      default: flip_vel = v;
    endcase
  endfunction

endpackage

// File: rtl/brick_collision_sched_if.sv
// Bundle of ball/brick geometry, keycode, velocity and scheduler status signals.
// Latency: wires only.
// Backpressure: none; the scheduler samples inputs live every cycle.
interface brick_collision_sched_if #(
  parameter int NUM_BRICKS = 10,
  parameter int SCORE_W    = 16
);
  logic [7:0]              keycode;
  logic [9:0]              BallX;
  logic [9:0]              BallY;
  logic [9:0]              BallS;
  logic [10*NUM_BRICKS-1:0] brick_x_vals;
  logic [10*NUM_BRICKS-1:0] brick_y_vals;
  logic [9:0]              brick_width;
  logic [9:0]              brick_height;
  logic [1:0]              velocity_x_cur;
  logic [1:0]              velocity_y_cur;
  logic [1:0]              velocity_x;
  logic [1:0]              velocity_y;
  logic [NUM_BRICKS-1:0]   brick_exists;
  logic                    hit_valid;
  logic [3:0]              hit_idx;
  logic                    scan_busy;
  logic [SCORE_W-1:0]      score;
  logic                    level_clear;
  logic                    overrun;

  // Game side: supplies geometry and key, consumes committed velocity and status
  modport master (
    output keycode, BallX, BallY, BallS, brick_x_vals, brick_y_vals,
           brick_width, brick_height, velocity_x_cur, velocity_y_cur,
    input  velocity_x, velocity_y, brick_exists, hit_valid, hit_idx,
           scan_busy, score, level_clear, overrun
  );

  // Scheduler side
  modport slave (
    input  keycode, BallX, BallY, BallS, brick_x_vals, brick_y_vals,
           brick_width, brick_height, velocity_x_cur, velocity_y_cur,
    output velocity_x, velocity_y, brick_exists, hit_valid, hit_idx,
           scan_busy, score, level_clear, overrun
  );
endinterface

// File: rtl/brick_overlap.sv
// Ball-versus-single-brick overlap test plus horizontal-span flag for bounce axis.
// Latency: combinational.
// Backpressure: none.
module brick_overlap (
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] ball_s,
  input  logic [9:0] brick_x,
  input  logic [9:0] brick_y,
  input  logic [9:0] brick_w,
  input  logic [9:0] brick_h,
  input  logic       brick_live,
  output logic       hit,
  output logic       in_x_span
);

  logic [10:0] x_last;
  logic [10:0] y_last;
  logic [10:0] ball_xr;
  logic [10:0] ball_yb;
  logic        x_ovl;
  logic        y_ovl;

  // Compare the ball box edges against the brick edges in 11 bits so sums never wrap
  always_comb begin
    x_last    = {1'b0, brick_x} + {1'b0, brick_w} - 11'd1;
    y_last    = {1'b0, brick_y} + {1'b0, brick_h} - 11'd1;
    ball_xr   = {1'b0, ball_x} + {1'b0, ball_s};
    ball_yb   = {1'b0, ball_y} + {1'b0, ball_s};
    x_ovl     = (ball_xr >= {1'b0, brick_x}) && ({1'b0, ball_x} <= x_last + {1'b0, ball_s});
    y_ovl     = (ball_yb >= {1'b0, brick_y}) && ({1'b0, ball_y} <= y_last + {1'b0, ball_s});
    hit       = brick_live && x_ovl && y_ovl;
    in_x_span = ({1'b0, ball_x} >= {1'b0, brick_x}) && ({1'b0, ball_x} <= x_last);
  end

endmodule

// File: rtl/brick_collision_sched.sv
// Per-frame brick scan: first live overlapped brick is cleared and the ball bounces, else key steers.
// Latency: commit outputs update NUM_BRICKS+2 Clk after the tick pulse (tick itself 2-3 Clk after frame_clk rise).
// Backpressure: none; a tick arriving while a scan is in flight is dropped and flagged in sticky overrun.
module brick_collision_sched #(
  parameter int NUM_BRICKS = 10,
  parameter int SCORE_W    = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_clk,
  brick_collision_sched_if.slave bus
);
  import game_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(NUM_BRICKS - 1);

  sched_state_t          state_q, state_d;
  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic                  edge_q, edge_d;
  logic [3:0]            idx_q, idx_d;
  logic                  hit_found_q, hit_found_d;
  logic [3:0]            hit_rec_q, hit_rec_d;
  logic                  hit_xspan_q, hit_xspan_d;
  vel_t                  bounce_vx_q, bounce_vx_d;
  vel_t                  bounce_vy_q, bounce_vy_d;
  vel_t                  velocity_x_q, velocity_x_d;
  vel_t                  velocity_y_q, velocity_y_d;
  logic [NUM_BRICKS-1:0] brick_exists_q, brick_exists_d;
  logic                  hit_valid_q, hit_valid_d;
  logic [3:0]            hit_idx_q, hit_idx_d;
  logic [SCORE_W-1:0]    score_q, score_d;
  logic                  overrun_q, overrun_d;

  logic       tick;
  logic [9:0] sel_x;
  logic [9:0] sel_y;
  logic       sel_live;
  logic       cand_hit;
  logic       cand_xspan;

  assign tick = sync2_q & ~edge_q;

  // Select the brick addressed by the scan index
  always_comb begin
    sel_x    = '0;
    sel_y    = '0;
    sel_live = 1'b0;
    for (int i = 0; i < NUM_BRICKS; i++) begin
      if (idx_q == 4'(i)) begin
        sel_x    = bus.brick_x_vals[i*10 +: 10];
        sel_y    = bus.brick_y_vals[i*10 +: 10];
        sel_live = brick_exists_q[i];
      end
    end
  end

  brick_overlap u_overlap (
    .ball_x     (bus.BallX),
    .ball_y     (bus.BallY),
    .ball_s     (bus.BallS),
    .brick_x    (sel_x),
    .brick_y    (sel_y),
    .brick_w    (bus.brick_width),
    .brick_h    (bus.brick_height),
    .brick_live (sel_live),
    .hit        (cand_hit),
    .in_x_span  (cand_xspan)
  );

  // Next-state: tick sync, scan sequencing, bounce resolution and commit arbitration
  always_comb begin
    state_d        = state_q;
    sync1_d        = frame_clk;
    sync2_d        = sync1_q;
    edge_d         = sync2_q;
    idx_d          = idx_q;
    hit_found_d    = hit_found_q;
    hit_rec_d      = hit_rec_q;
    hit_xspan_d    = hit_xspan_q;
    bounce_vx_d    = bounce_vx_q;
    bounce_vy_d    = bounce_vy_q;
    velocity_x_d   = velocity_x_q;
    velocity_y_d   = velocity_y_q;
    brick_exists_d = brick_exists_q;
    hit_valid_d    = 1'b0;
    hit_idx_d      = hit_idx_q;
    score_d        = score_q;
    overrun_d      = overrun_q;

    // Any tick that lands outside IDLE (including the COMMIT cycle) is lost
    if (tick && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d     = ST_SCAN;
          idx_d       = '0;
          hit_found_d = 1'b0;
        end
      end
      ST_SCAN: begin
        // Lowest index wins; the span flag is the geometry snapshot used for the bounce axis
        if (!hit_found_q && cand_hit) begin
          hit_found_d = 1'b1;
          hit_rec_d   = idx_q;
          hit_xspan_d = cand_xspan;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_RESOLVE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      ST_RESOLVE: begin
        // Ball centre over the brick's columns means it struck top/bottom
        if (hit_xspan_q) begin
          bounce_vx_d = bus.velocity_x_cur;
          bounce_vy_d = flip_vel(bus.velocity_y_cur);
        end else begin
          bounce_vx_d = flip_vel(bus.velocity_x_cur);
          bounce_vy_d = bus.velocity_y_cur;
        end
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (hit_found_q) begin
          velocity_x_d = bounce_vx_q;
          velocity_y_d = bounce_vy_q;
          for (int i = 0; i < NUM_BRICKS; i++) begin
            if (hit_rec_q == 4'(i)) begin
              brick_exists_d[i] = 1'b0;
            end
          end
          hit_valid_d = 1'b1;
          hit_idx_d   = hit_rec_q;
          if (score_q != {SCORE_W{1'b1}}) begin
            score_d = score_q + SCORE_W'(1);
          end
        end else begin
          case (bus.keycode)
            KEY_W: begin velocity_x_d = VEL_STOP; velocity_y_d = VEL_NEG;  end
            KEY_S: begin velocity_x_d = VEL_STOP; velocity_y_d = VEL_POS;  end
            KEY_A: begin velocity_x_d = VEL_NEG;  velocity_y_d = VEL_STOP; end
            KEY_D: begin velocity_x_d = VEL_POS;  velocity_y_d = VEL_STOP; end
            default: begin
              velocity_x_d = bus.velocity_x_cur;
              velocity_y_d = bus.velocity_y_cur;
            end
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any scan without committing
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q        <= ST_IDLE;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      edge_q         <= 1'b0;
      idx_q          <= '0;
      hit_found_q    <= 1'b0;
      hit_rec_q      <= '0;
      hit_xspan_q    <= 1'b0;
      bounce_vx_q    <= VEL_STOP;
      bounce_vy_q    <= VEL_STOP;
      velocity_x_q   <= VEL_STOP;
      velocity_y_q   <= VEL_STOP;
      brick_exists_q <= '1;
      hit_valid_q    <= 1'b0;
      hit_idx_q      <= '0;
      score_q        <= '0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      edge_q         <= edge_d;
      idx_q          <= idx_d;
      hit_found_q    <= hit_found_d;
      hit_rec_q      <= hit_rec_d;
      hit_xspan_q    <= hit_xspan_d;
      bounce_vx_q    <= bounce_vx_d;
      bounce_vy_q    <= bounce_vy_d;
      velocity_x_q   <= velocity_x_d;
      velocity_y_q   <= velocity_y_d;
      brick_exists_q <= brick_exists_d;
      hit_valid_q    <= hit_valid_d;
      hit_idx_q      <= hit_idx_d;
      score_q        <= score_d;
      overrun_q      <= overrun_d;
    end
  end

  assign bus.velocity_x   = velocity_x_q;
  assign bus.velocity_y   = velocity_y_q;
  assign bus.brick_exists = brick_exists_q;
  assign bus.hit_valid    = hit_valid_q;
  assign bus.hit_idx      = hit_idx_q;
  assign bus.scan_busy    = (state_q != ST_IDLE);
  assign bus.score        = score_q;
  assign bus.level_clear  = (brick_exists_q == '0);
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_brick_collision_sched.sv
// Self-checking bench: directed frame table, hand-written overrun/reset sequences, random frames vs model.
// A second instance with a 2-bit score exercises saturation in lockstep with the main one.
`timescale 1ns/1ps
module tb_brick_collision_sched;

  localparam int NB = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'd0;
  logic [9:0] ball_x = '0, ball_y = '0, ball_s = '0;
  logic [9:0] brick_w = 10'd40, brick_h = 10'd10;
  logic [1:0] vxc = 2'b00, vyc = 2'b00;
  logic [9:0] bx [NB];
  logic [9:0] by [NB];
  logic [10*NB-1:0] bx_vec, by_vec;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_exists [NB];
  int m_score;

  always_comb begin
    bx_vec = '0;
    by_vec = '0;
    for (int i = 0; i < NB; i++) begin
      bx_vec[i*10 +: 10] = bx[i];
      by_vec[i*10 +: 10] = by[i];
    end
  end

  brick_collision_sched_if #(.NUM_BRICKS(NB), .SCORE_W(16)) bus_a ();
  brick_collision_sched_if #(.NUM_BRICKS(NB), .SCORE_W(2))  bus_b ();

  assign bus_a.keycode = keycode;        assign bus_b.keycode = keycode;
  assign bus_a.BallX = ball_x;           assign bus_b.BallX = ball_x;
  assign bus_a.BallY = ball_y;           assign bus_b.BallY = ball_y;
  assign bus_a.BallS = ball_s;           assign bus_b.BallS = ball_s;
  assign bus_a.brick_x_vals = bx_vec;    assign bus_b.brick_x_vals = bx_vec;
  assign bus_a.brick_y_vals = by_vec;    assign bus_b.brick_y_vals = by_vec;
  assign bus_a.brick_width = brick_w;    assign bus_b.brick_width = brick_w;
  assign bus_a.brick_height = brick_h;   assign bus_b.brick_height = brick_h;
  assign bus_a.velocity_x_cur = vxc;     assign bus_b.velocity_x_cur = vxc;
  assign bus_a.velocity_y_cur = vyc;     assign bus_b.velocity_y_cur = vyc;

  brick_collision_sched #(.NUM_BRICKS(NB), .SCORE_W(16)) dut_a (
    .Clk(clk), .Reset(rst_n), .frame_clk(frame_clk), .bus(bus_a));
  brick_collision_sched #(.NUM_BRICKS(NB), .SCORE_W(2)) dut_b (
    .Clk(clk), .Reset(rst_n), .frame_clk(frame_clk), .bus(bus_b));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [1:0] m_flip(input logic [1:0] v);
    if (v == 2'b01) return 2'b10;
    if (v == 2'b10) return 2'b01;
    return v;
  endfunction

  // What one frame should commit, from the rules applied to the current inputs
  function automatic void predict(output logic [1:0] evx, output logic [1:0] evy,
                                  output bit ehit, output int eidx);
    int cx, cy, s, w, h, x0, y0;
    cx = int'(ball_x); cy = int'(ball_y); s = int'(ball_s);
    w = int'(brick_w); h = int'(brick_h);
    ehit = 1'b0; eidx = 0;
    for (int i = 0; i < NB; i++) begin
      x0 = int'(bx[i]); y0 = int'(by[i]);
      if (!ehit && m_exists[i] && cx + s >= x0 && cx <= x0 + w - 1 + s &&
          cy + s >= y0 && cy <= y0 + h - 1 + s) begin
        ehit = 1'b1; eidx = i;
      end
    end
    if (ehit) begin
      x0 = int'(bx[eidx]);
      if (cx >= x0 && cx <= x0 + w - 1) begin evx = vxc; evy = m_flip(vyc); end
      else begin evx = m_flip(vxc); evy = vyc; end
    end else if (keycode == 8'd26) begin evx = 2'b00; evy = 2'b10; end
    else if (keycode == 8'd22) begin evx = 2'b00; evy = 2'b01; end
    else if (keycode == 8'd4)  begin evx = 2'b10; evy = 2'b00; end
    else if (keycode == 8'd7)  begin evx = 2'b01; evy = 2'b00; end
    else begin evx = vxc; evy = vyc; end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; frame_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NB; i++) m_exists[i] = 1'b1;
    m_score = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " vx"}, bus_a.velocity_x, 0);
    check({tag, " vy"}, bus_a.velocity_y, 0);
    check({tag, " exists"}, bus_a.brick_exists, 'h3FF);
    check({tag, " score"}, bus_a.score, 0);
    check({tag, " overrun"}, bus_a.overrun, 0);
    check({tag, " hit_valid"}, bus_a.hit_valid, 0);
    check({tag, " hit_idx"}, bus_a.hit_idx, 0);
    check({tag, " busy"}, bus_a.scan_busy, 0);
    check({tag, " level_clear"}, bus_a.level_clear, 0);
  endtask

  task automatic set_layout_fixed();
    int xs [NB] = '{0, 60, 120, 100, 240, 120, 360, 420, 480, 540};
    for (int i = 0; i < NB; i++) begin
      bx[i] = 10'(xs[i]);
      by[i] = (i == 3) ? 10'd50 : 10'd300;
    end
    brick_w = 10'd40; brick_h = 10'd10;
  endtask

  task automatic pulse_frame();
    @(negedge clk); frame_clk = 1'b1;
    @(negedge clk); frame_clk = 1'b0;
  endtask

  // Run one frame and compare; table values override model expectations when use_tbl is set
  task automatic do_frame(input string tag, input bit use_tbl, input logic [1:0] tvx,
                          input logic [1:0] tvy, input bit thit, input int tidx);
    logic [1:0] mvx, mvy, evx, evy;
    bit mhit, ehit;
    int midx, eidx, waitc, busy, hits, sat;
    logic [NB-1:0] mvec;
    predict(mvx, mvy, mhit, midx);
    evx = use_tbl ? tvx : mvx; evy = use_tbl ? tvy : mvy;
    ehit = use_tbl ? thit : mhit; eidx = use_tbl ? tidx : midx;
    pulse_frame();
    waitc = 0;
    while (!bus_a.scan_busy && waitc < 10) begin @(negedge clk); waitc++; end
    if (!bus_a.scan_busy) begin
      checks++; errors++;
      $display("FAIL %s start: scan_busy did not rise within 10 cycles", tag);
    end
    busy = 0; hits = 0;
    while (bus_a.scan_busy && busy < 100) begin
      hits += int'(bus_a.hit_valid); busy++; @(negedge clk);
    end
    check({tag, " busy_len"}, busy, NB + 2);
    hits += int'(bus_a.hit_valid);
    check({tag, " vx"}, bus_a.velocity_x, evx);
    check({tag, " vy"}, bus_a.velocity_y, evy);
    if (ehit) check({tag, " hit_idx"}, bus_a.hit_idx, eidx);
    @(negedge clk);
    hits += int'(bus_a.hit_valid);
    check({tag, " hit_pulses"}, hits, ehit ? 1 : 0);
    if (mhit) begin
      m_exists[midx] = 1'b0;
      if (m_score < 65535) m_score++;
    end
    for (int i = 0; i < NB; i++) mvec[i] = m_exists[i];
    check({tag, " exists"}, bus_a.brick_exists, mvec);
    check({tag, " score"}, bus_a.score, m_score);
    check({tag, " level_clear"}, bus_a.level_clear, (mvec == '0) ? 1 : 0);
    sat = (m_score > 3) ? 3 : m_score;
    check({tag, " score_sat2"}, bus_b.score, sat);
  endtask

  typedef struct {
    logic [9:0] x, y, s;
    logic [7:0] key;
    logic [1:0] vxc, vyc, evx, evy;
    bit         ehit;
    int         eidx;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int nh, nb, prev_busy, j, off;
    for (int i = 0; i < NB; i++) begin bx[i] = '0; by[i] = '0; end
    set_layout_fixed();
    tbl[0] = '{10'd320, 10'd400, 10'd4, 8'd7,  2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 0}; // no hit, D
    tbl[1] = '{10'd120, 10'd62,  10'd4, 8'd26, 2'b01, 2'b10, 2'b01, 2'b01, 1'b1, 3}; // top bounce, W ignored
    tbl[2] = '{10'd140, 10'd305, 10'd4, 8'd0,  2'b10, 2'b01, 2'b10, 2'b10, 1'b1, 2}; // 2 and 5 overlap
    tbl[3] = '{10'd140, 10'd305, 10'd4, 8'd0,  2'b10, 2'b01, 2'b10, 2'b10, 1'b1, 5}; // then 5
    tbl[4] = '{10'd140, 10'd305, 10'd4, 8'd4,  2'b01, 2'b01, 2'b10, 2'b00, 1'b0, 0}; // both gone, A
    tbl[5] = '{10'd56,  10'd305, 10'd4, 8'd0,  2'b01, 2'b00, 2'b10, 2'b00, 1'b1, 1}; // side hit brick1
    tbl[6] = '{10'd320, 10'd400, 10'd4, 8'd9,  2'b10, 2'b01, 2'b10, 2'b01, 1'b0, 0}; // other key: hold
    tbl[7] = '{10'd43,  10'd305, 10'd4, 8'd22, 2'b11, 2'b01, 2'b11, 2'b01, 1'b1, 0}; // 11 passes through
    tbl[8] = '{10'd320, 10'd400, 10'd4, 8'd22, 2'b01, 2'b10, 2'b00, 2'b01, 1'b0, 0}; // S

    do_reset();
    check_reset_state("reset");

    for (int r = 0; r < 9; r++) begin
      ball_x = tbl[r].x; ball_y = tbl[r].y; ball_s = tbl[r].s;
      keycode = tbl[r].key; vxc = tbl[r].vxc; vyc = tbl[r].vyc;
      do_frame($sformatf("row%0d", r), 1'b1, tbl[r].evx, tbl[r].evy, tbl[r].ehit, tbl[r].eidx);
    end
    check("table overrun", bus_a.overrun, 0);

    // Side hit on brick 3 from the left, then the same position finds nothing
    do_reset();
    ball_x = 10'd96; ball_y = 10'd55; ball_s = 10'd4; keycode = 8'd0; vxc = 2'b01; vyc = 2'b00;
    do_frame("side", 1'b1, 2'b10, 2'b00, 1'b1, 3);
    do_frame("side_again", 1'b0, 2'b00, 2'b00, 1'b0, 0);

    // Second tick three clocks after the first: one commit, overrun set
    do_reset();
    ball_x = 10'd120; ball_y = 10'd62; ball_s = 10'd4; vxc = 2'b01; vyc = 2'b10;
    @(negedge clk); frame_clk = 1'b1;
    @(negedge clk); frame_clk = 1'b0;
    @(negedge clk);
    @(negedge clk); frame_clk = 1'b1;
    @(negedge clk); frame_clk = 1'b0;
    nh = 0; nb = 0; prev_busy = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      nh += int'(bus_a.hit_valid);
      if (bus_a.scan_busy && prev_busy == 0) nb++;
      prev_busy = int'(bus_a.scan_busy);
    end
    check("ovr overrun", bus_a.overrun, 1);
    check("ovr commits", nh, 1);
    check("ovr scans", nb, 1);
    check("ovr score", bus_a.score, 1);
    check("ovr exists", bus_a.brick_exists, 'h3F7);

    // Reset in the middle of a scan: nothing commits
    do_reset();
    check("rst overrun_clear", bus_a.overrun, 0);
    pulse_frame();
    j = 0;
    while (!bus_a.scan_busy && j < 10) begin @(negedge clk); j++; end
    check("rst scan_started", bus_a.scan_busy, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("midscan");
    nh = 0;
    for (int c = 0; c < 20; c++) begin @(negedge clk); nh += int'(bus_a.hit_valid); end
    check("midscan no_commit", nh, 0);
    check("midscan exists_kept", bus_a.brick_exists, 'h3FF);

    // Random layouts and frames against the model
    do_reset();
    for (int i = 0; i < NB; i++) begin
      bx[i] = 10'($urandom_range(0, 300));
      by[i] = 10'($urandom_range(0, 300));
    end
    brick_w = 10'($urandom_range(1, 40));
    brick_h = 10'($urandom_range(1, 20));
    for (int f = 0; f < 40; f++) begin
      ball_s = 10'($urandom_range(0, 8));
      if ($urandom_range(0, 3) != 0) begin
        j = int'($urandom_range(0, NB - 1));
        off = int'(bx[j]) + int'($urandom_range(0, int'(brick_w) - 1 + 2 * int'(ball_s)));
        ball_x = (off < int'(ball_s)) ? 10'd0 : 10'(off - int'(ball_s));
        off = int'(by[j]) + int'($urandom_range(0, int'(brick_h) - 1 + 2 * int'(ball_s)));
        ball_y = (off < int'(ball_s)) ? 10'd0 : 10'(off - int'(ball_s));
      end else begin
        ball_x = 10'($urandom_range(0, 350));
        ball_y = 10'($urandom_range(0, 350));
      end
      case ($urandom_range(0, 5))
        0: keycode = 8'd26;
        1: keycode = 8'd22;
        2: keycode = 8'd4;
        3: keycode = 8'd7;
        4: keycode = 8'd0;
        default: keycode = 8'd9;
      endcase
      vxc = 2'($urandom_range(0, 3));
      vyc = 2'($urandom_range(0, 3));
      do_frame($sformatf("rand%0d", f), 1'b0, 2'b00, 2'b00, 1'b0, 0);
    end
    check("rand overrun", bus_a.overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
